// File: rtl/prime_gen_if.sv
// ---------------------------------------------------------------------------
// prime_gen_if -- request/stream bundle for the prime generator.
//
// Signals
//   start     : request to stream every prime <= limit
//   limit     : 8-bit unsigned upper bound, captured when start is accepted
//   out_ready : consumer accepts the presented prime when high with out_valid
//   busy      : generator is not idle
//   out_valid : prime carries a valid prime
//   prime     : current prime value
//   done      : one-cycle pulse at the end of a stream
//
// Modports
//   master : requester/consumer side (drives start, limit, out_ready)
//   slave  : generator side (drives busy, out_valid, prime, done)
// ---------------------------------------------------------------------------
interface prime_gen_if;
  logic       start;
  logic [7:0] limit;
  logic       out_ready;
  logic       busy;
  logic       out_valid;
  logic [7:0] prime;
  logic       done;

  modport master (
    output start,
    output limit,
    output out_ready,
    input  busy,
    input  out_valid,
    input  prime,
    input  done
  );

  modport slave (
    input  start,
    input  limit,
    input  out_ready,
    output busy,
    output out_valid,
    output prime,
    output done
  );
endinterface

// File: rtl/prime_gen.sv
// ---------------------------------------------------------------------------
// prime_gen -- streams every prime from 2 up to a captured limit, in
// ascending order, over a valid/ready handshake. Primality is tested by
// trial division where each division is done by repeated subtraction, one
// subtraction per clock.
//
// Ports
//   clk   : single clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : prime_gen_if.slave (start, limit, out_ready in;
//           busy, out_valid, prime, done out)
// ---------------------------------------------------------------------------
module prime_gen (
  input  logic        clk,
  input  logic        rst_n,
  prime_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST_INIT,
    S_DIV,
    S_EMIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] lim_q,   lim_d;
  logic [7:0] cand_q,  cand_d;
  logic [4:0] div_q,   div_d;
  logic [7:0] rem_q,   rem_d;
  logic [7:0] prime_q, prime_d;
  logic       busy_q,  busy_d;
  logic       valid_q, valid_d;
  logic       done_q,  done_d;

  // Next divisor and its square. The divisor never exceeds 16 for an
  // 8-bit candidate, so 5 bits and a 10-bit square are enough.
  logic [4:0] div_inc;
  logic [9:0] inc_sq;
  logic [7:0] div_ext;

  assign div_inc = div_q + 5'd1;
  assign inc_sq  = {5'd0, div_inc} * {5'd0, div_inc};
  assign div_ext = {3'd0, div_q};

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    cand_d  = cand_q;
    div_d   = div_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          lim_d   = bus.limit;
          cand_d  = 8'd2;
          state_d = (bus.limit >= 8'd2) ? S_TEST_INIT : S_DONE;
        end
      end

      S_TEST_INIT: begin
        div_d   = 5'd2;
        rem_d   = cand_q;
        state_d = (10'd4 > {2'd0, cand_q}) ? S_EMIT : S_DIV;
      end

      S_DIV: begin
        if (rem_q >= div_ext) begin
          rem_d = rem_q - div_ext;
        end else if (rem_q == 8'd0) begin
          // Exact division: composite, skip to the next candidate.
          state_d = S_ADVANCE;
        end else begin
          div_d   = div_inc;
          rem_d   = cand_q;
          state_d = (inc_sq > {2'd0, cand_q}) ? S_EMIT : S_DIV;
        end
      end

      S_EMIT: begin
        if (bus.out_ready) begin
          state_d = S_ADVANCE;
        end
      end

      S_ADVANCE: begin
        // Stop on equality so a limit of 255 never wraps the candidate.
        if (cand_q == lim_q) begin
          state_d = S_DONE;
        end else begin
          cand_d  = cand_q + 8'd1;
          state_d = S_TEST_INIT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered and decoded from the upcoming state so they
    // line up with the state register.
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_EMIT);
    done_d  = (state_d == S_DONE);
    prime_d = (state_d == S_EMIT) ? cand_d : prime_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lim_q   <= 8'd0;
      cand_q  <= 8'd0;
      div_q   <= 5'd0;
      rem_q   <= 8'd0;
      prime_q <= 8'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      cand_q  <= cand_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      prime_q <= prime_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.prime     = prime_q;
  assign bus.done      = done_q;

endmodule
